// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset controller: per-state sequencing of datapath enables and selects,
// ARM condition evaluation and the stored NZCV flags register.
module multicycle_control_unit #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic [3:0]         alu_flags,
    output logic               pc_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic               adr_src,
    output logic [1:0]         reg_src,
    output logic [1:0]         imm_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [3:0]         alu_control,
    output logic [3:0]         flags_o,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_flags;

    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic [3:0]  w_cmd;
    logic [3:0]  w_cond;
    logic        w_rd_pc;
    logic        w_cond_ex;
    logic        w_is_cmp;
    logic [3:0]  w_alu_dec;
    logic        w_unused;

    logic        w_pc_write, w_ir_write, w_reg_write, w_mem_write;

    assign w_op     = instr[27:26];
    assign w_funct  = instr[25:20];
    assign w_cmd    = w_funct[4:1];
    assign w_cond   = instr[31:28];
    assign w_rd_pc  = (instr[15:12] == 4'b1111);
    assign w_is_cmp = (w_cmd == 4'b1010);
    assign w_unused = ^{instr[19:16], instr[11:0]};

    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = ~r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = ~r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = ~r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = ~r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
            4'b1001: w_cond_ex = ~r_flags[1] | r_flags[2];
            4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        case (w_cmd)
            4'b0010, 4'b1010: w_alu_dec = 4'b0001;
            4'b0000:          w_alu_dec = 4'b0010;
            4'b1100:          w_alu_dec = 4'b0011;
            default:          w_alu_dec = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Flags capture on the edge that leaves an execute state, gated by S bit and condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if ((r_state == EXECR || r_state == EXECI) && w_funct[0] && w_cond_ex) begin
            r_flags <= alu_flags;
        end
    end

    always_comb begin
        w_next      = FETCH;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        adr_src     = 1'b0;
        reg_src     = '0;
        alu_src_a   = '0;
        alu_src_b   = '0;
        result_src  = '0;
        alu_control = '0;
        case (r_state)
            FETCH: begin
                w_next     = DECODE;
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                case (w_op)
                    2'b00:   w_next = w_funct[5] ? EXECI : EXECR;
                    2'b01:   w_next = MEMADR;
                    2'b10:   w_next = BRANCH;
                    default: w_next = FETCH;
                endcase
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_src    = {(w_op == 2'b01), (w_op == 2'b10)};
            end
            MEMADR: begin
                w_next    = w_funct[0] ? MEMREAD : MEMWRITE;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                w_next  = MEMWB;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = w_cond_ex;
                w_pc_write  = w_cond_ex & w_rd_pc;
            end
            MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = w_cond_ex;
            end
            EXECR: begin
                w_next      = ALUWB;
                alu_control = w_alu_dec;
            end
            EXECI: begin
                w_next      = ALUWB;
                alu_src_b   = 2'b01;
                alu_control = w_alu_dec;
            end
            ALUWB: begin
                w_reg_write = w_cond_ex & ~w_is_cmp;
                w_pc_write  = w_cond_ex & ~w_is_cmp & w_rd_pc;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                w_pc_write = w_cond_ex;
            end
            default: w_next = FETCH;
        endcase
    end

    assign pc_write  = w_pc_write  & ~reset;
    assign ir_write  = w_ir_write  & ~reset;
    assign reg_write = w_reg_write & ~reset;
    assign mem_write = w_mem_write & ~reset;
    assign imm_src   = w_op;
    assign flags_o   = r_flags;
    assign state_o   = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: an instruction-level model predicts the state
// walk and every output per cycle; literal expectations pin key results.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        pc_write, ir_write, reg_write, mem_write, adr_src;
    logic [1:0]  reg_src, imm_src, alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_control, flags_o;
    logic [3:0]  state_o;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] m_flags;
    int         mw_cnt, rw_cnt, pc9, adr3, rs1;
    logic [3:0] ctl_exec;
    logic [1:0] srcb_exec, res4;

    multicycle_control_unit #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_write(mem_write), .adr_src(adr_src), .reg_src(reg_src),
        .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_control(alu_control),
        .flags_o(flags_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // ARM condition: even codes name a predicate, odd codes are its negation.
    function automatic bit cond_ok(input logic [31:0] ins, input logic [3:0] f);
        logic [3:0] c;
        bit n, z, cy, v, base;
        c = ins[31:28];
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [3:0] alu_op(input logic [31:0] ins);
        logic [3:0] cmd;
        cmd = ins[24:21];
        if (cmd == 4'b0010 || cmd == 4'b1010) return 4'b0001;
        if (cmd == 4'b0000) return 4'b0010;
        if (cmd == 4'b1100) return 4'b0011;
        return 4'b0000;
    endfunction

    // Bundle: pc, ir, rw, mw, adr, reg_src, imm_src, src_a, src_b, result_src, alu_control
    function automatic logic [18:0] expect_out(input int st, input logic [31:0] ins, input logic [3:0] f);
        bit ce, wb, pc, ir, rw, mw, adr;
        logic [1:0] rs, sa, sb, res;
        logic [3:0] ctl;
        ce = cond_ok(ins, f);
        wb = (ins[24:21] != 4'b1010);
        {pc, ir, rw, mw, adr} = '0;
        rs = '0; sa = '0; sb = '0; res = '0; ctl = '0;
        if (st == 0) begin pc = 1; ir = 1; sa = 2'b01; sb = 2'b10; res = 2'b10; end
        if (st == 1) begin sa = 2'b01; sb = 2'b10; res = 2'b10;
            rs = {ins[27:26] == 2'b01, ins[27:26] == 2'b10}; end
        if (st == 2) sb = 2'b01;
        if (st == 3) adr = 1;
        if (st == 4) begin res = 2'b01; rw = ce; pc = ce && ins[15:12] == 4'hF; end
        if (st == 5) begin adr = 1; mw = ce; end
        if (st == 6) ctl = alu_op(ins);
        if (st == 7) begin sb = 2'b01; ctl = alu_op(ins); end
        if (st == 8) begin rw = ce && wb; pc = ce && wb && ins[15:12] == 4'hF; end
        if (st == 9) begin sb = 2'b01; res = 2'b10; pc = ce; end
        return {pc, ir, rw, mw, adr, rs, ins[27:26], sa, sb, res, ctl};
    endfunction

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_cycle(input int st, input logic [31:0] ins);
        logic [18:0] got;
        got = {pc_write, ir_write, reg_write, mem_write, adr_src, reg_src, imm_src,
               alu_src_a, alu_src_b, result_src, alu_control};
        lit($sformatf("state ins=%h", ins), 32'(state_o), 32'(st));
        lit($sformatf("outputs ins=%h st=%0d", ins, st), 32'(got), 32'(expect_out(st, ins, m_flags)));
        lit($sformatf("flags ins=%h st=%0d", ins, st), 32'(flags_o), 32'(m_flags));
        if (mem_write) mw_cnt++;
        if (reg_write) rw_cnt++;
        if (st == 9) pc9 = int'(pc_write);
        if (st == 3) adr3 = int'(adr_src);
        if (st == 4) res4 = result_src;
        if (st == 1) rs1 = int'(reg_src);
        if (st == 6 || st == 7) begin ctl_exec = alu_control; srcb_exec = alu_src_b; end
    endtask

    function automatic void build_seq(input logic [31:0] ins, output int seq[$]);
        seq = {0, 1};
        case (ins[27:26])
            2'b00: seq = {0, 1, ins[25] ? 7 : 6, 8};
            2'b01: seq = ins[20] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'b10: seq = {0, 1, 9};
            default: ;
        endcase
    endfunction

    task automatic run(input logic [31:0] ins, input logic [3:0] af);
        int seq[$];
        build_seq(ins, seq);
        mw_cnt = 0; rw_cnt = 0; pc9 = -1; adr3 = -1; rs1 = -1;
        @(negedge clk);
        instr = ins;
        alu_flags = af;
        for (int k = 0; k < seq.size(); k++) begin
            if (k > 0) @(negedge clk);
            #1 check_cycle(seq[k], ins);
            @(posedge clk);
            if ((seq[k] == 6 || seq[k] == 7) && ins[20] && cond_ok(ins, m_flags)) m_flags = af;
        end
    endtask

    initial begin
        reset = 1'b1;
        instr = 32'hE0821003;
        alu_flags = 4'b0000;
        m_flags = 4'b0000;
        #1;
        lit("reset state", 32'(state_o), 0);
        lit("reset flags", 32'(flags_o), 0);
        lit("reset enables", 32'({pc_write, ir_write, reg_write, mem_write}), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run(32'hE0821003, 4'b1111);
        lit("ADD alu_control", 32'(ctl_exec), 32'b0000);
        lit("ADD reg_write count", 32'(rw_cnt), 1);
        lit("ADD flags hold", 32'(flags_o), 0);

        run(32'hE2500000, 4'b0100);
        lit("SUBS alu_control", 32'(ctl_exec), 32'b0001);
        lit("SUBS alu_src_b", 32'(srcb_exec), 32'b01);
        lit("SUBS flags", 32'(flags_o), 32'b0100);
        run(32'h0A000002, 4'b0000);
        lit("BEQ pc_write", 32'(pc9), 1);
        run(32'h1A000002, 4'b0000);
        lit("BNE pc_write", 32'(pc9), 0);

        run(32'hE5954008, 4'b0000);
        lit("LDR adr_src MEMREAD", 32'(adr3), 1);
        lit("LDR result_src MEMWB", 32'(res4), 32'b01);
        lit("LDR reg_write count", 32'(rw_cnt), 1);
        run(32'hE5854008, 4'b0000);
        lit("STR mem_write count", 32'(mw_cnt), 1);
        lit("STR reg_src DECODE", 32'(rs1), 32'b10);
        lit("STR reg_write count", 32'(rw_cnt), 0);

        run(32'hE1510002, 4'b1000);
        lit("CMP reg_write count", 32'(rw_cnt), 0);
        lit("CMP flags", 32'(flags_o), 32'b1000);
        run(32'hE2500000, 4'b0100);
        run(32'h00821003, 4'b1111);
        lit("ADDEQ reg_write count", 32'(rw_cnt), 1);
        run(32'h10821003, 4'b1111);
        lit("ADDNE reg_write count", 32'(rw_cnt), 0);

        run(32'hE1821003, 4'b0000);
        lit("ORR alu_control", 32'(ctl_exec), 32'b0011);
        run(32'hE0021003, 4'b0000);
        lit("AND alu_control", 32'(ctl_exec), 32'b0010);
        run(32'hE0221003, 4'b0000);
        lit("EOR falls to ADD", 32'(ctl_exec), 32'b0000);
        run(32'hE082F003, 4'b0000);
        run(32'h15954008, 4'b0000);
        lit("LDRNE suppressed", 32'(rw_cnt), 0);
        run(32'hF0821003, 4'b0000);
        lit("cond 1111 suppressed", 32'(rw_cnt), 0);
        run(32'hEC000000, 4'b0000);
        run(32'h03A0F000, 4'b0000);
        lit("flags before reset test", 32'(flags_o), 32'b0100);

        // Reset asserted mid-LDR, while in MEMREAD.
        @(negedge clk);
        instr = 32'hE5954008;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1 check_cycle(k, instr);
            if (k < 3) @(posedge clk);
        end
        #2 reset = 1'b1;
        #1;
        lit("async reset state", 32'(state_o), 0);
        lit("async reset flags", 32'(flags_o), 0);
        lit("async reset enables", 32'({pc_write, ir_write, reg_write, mem_write}), 0);
        @(posedge clk);
        #1 lit("held reset enables", 32'({pc_write, ir_write, reg_write, mem_write}), 0);
        lit("held reset state", 32'(state_o), 0);
        @(negedge clk);
        reset = 1'b0;
        m_flags = 4'b0000;
        #1 lit("post-release ir_write", 32'(ir_write), 1);
        lit("post-release state", 32'(state_o), 0);
        @(posedge clk);
        #1 lit("first edge -> DECODE", 32'(state_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle ARM-subset controller. It consumes the 32-bit instruction from InstructionMemory and the NZCV flags from ALU.
- It drives every enable and mux select for the Program_Counter, instruction register, REGISTER_FILE_STRUCTURAL, ALU and data memory.
- It replaces the hard-wired we3/alu_control ties in the single-cycle CPU, so that ADD/SUB/AND/ORR/CMP, LDR/STR and B run with per-state sequencing.

Parameters:
- STATE_W, 4, width of the state register and of state_o.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr  in  32  current instruction (from the instruction register); cond=[31:28], op=[27:26], funct=[25:20], rd=[15:12]
- alu_flags  in  4  ALU output_flags: [3]=N, [2]=Z, [1]=C, [0]=V
- pc_write  out  1  Program_Counter load enable
- ir_write  out  1  instruction register load enable
- reg_write  out  1  register-file WE3
- mem_write  out  1  data-memory write enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- reg_src  out  2  [0]: A1=15; [1]: A2=rd
- imm_src  out  2  immediate extend type
- alu_src_a  out  2  ALU A select: 00=reg A, 01=PC
- alu_src_b  out  2  ALU B select: 00=reg B, 01=ExtImm, 10=constant 4
- result_src  out  2  result select: 00=ALUOut, 01=read data, 10=ALU result
- alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR
- flags_o  out  4  stored NZCV register
- state_o  out  STATE_W  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 return to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - From DECODE: op=00 & funct[5]=0 → EXECR; op=00 & funct[5]=1 → EXECI; op=01 → MEMADR; op=10 → BRANCH; op=11 → FETCH (NOP).
  - From MEMADR: funct[0]=1 → MEMREAD, else MEMWRITE.
  - MEMREAD→MEMWB; EXECR and EXECI→ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH→FETCH.
- Moore outputs; every signal not listed for a state is 0:
  - FETCH: ir_write=1, pc_write=1, adr_src=0, alu_src_a=01, alu_src_b=10, alu_control=ADD, result_src=10.
  - DECODE: alu_src_a=01, alu_src_b=10, alu_control=ADD, result_src=10, reg_src[0]=(op==10), reg_src[1]=(op==01).
  - MEMADR: alu_src_a=00, alu_src_b=01, alu_control=ADD.
  - MEMREAD: adr_src=1.
  - MEMWRITE: adr_src=1, mem_write=CondEx.
  - MEMWB: result_src=01, reg_write=CondEx.
  - EXECR / EXECI: alu_src_b=00 / 01, alu_control=decoded.
  - ALUWB: result_src=00, reg_write=CondEx & (cmd≠1010).
  - BRANCH: alu_src_a=00, alu_src_b=01, alu_control=ADD, result_src=10, pc_write=CondEx.
- imm_src = instr[27:26] in every state.
- ALU decode, cmd=funct[4:1]:
  - 0100 → ADD; 0010 → SUB; 0000 → AND; 1100 → ORR.
  - 1010 (CMP) → SUB with no write-back.
  - Any other cmd → ADD.
- Rd=15 write-back: in MEMWB/ALUWB with rd=1111 and CondEx=1, pc_write=1 in addition to reg_write.
- CondEx is combinational from cond and flags_o, using standard ARM conditions:
  - EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - cond=1111 evaluates as 0.
- A failed condition suppresses reg_write, mem_write and the branch/Rd=15 pc_write. FETCH's pc_write is never suppressed.
- Flags register: on the rising edge leaving EXECR/EXECI, flags_o<=alu_flags when funct[0]=1 (S bit) and CondEx=1; otherwise it holds.
- Reset (asynchronous, any state, mid-instruction included):
  - state=FETCH and flags_o=0000 immediately.
  - While reset=1, pc_write, ir_write, reg_write and mem_write are forced to 0.
  - The first FETCH cycle occurs on the first rising edge after reset deasserts.
- Latency in cycles: ALU op 4, LDR 5, STR 4, B 3, undefined op 2.

Test Plan:
- 0xE0821003 (ADD R1,R2,R3) → state 0,1,6,8,0; alu_control=0000 in EXECR; reg_write=1 only in ALUWB; flags_o unchanged.
- 0xE2500000 (SUBS R0,R0,#0) with alu_flags=0100 in EXECI → alu_control=0001, alu_src_b=01, flags_o=0100 after EXECI. Then 0x0A000002 (BEQ) → BRANCH pc_write=1. Then 0x1A000002 (BNE) → BRANCH pc_write=0.
- 0xE5954008 (LDR R4,[R5,#8]) → state 0,1,2,3,4,0; adr_src=1 in MEMREAD; result_src=01 and reg_write=1 in MEMWB.
- 0xE5854008 (STR) → state 0,1,2,5,0; mem_write=1 for exactly one cycle; reg_src=10 in DECODE; reg_write never asserted.
- 0xE1510002 (CMP R1,R2) with alu_flags=1000 → reg_write=0 in ALUWB; flags_o=1000. With flags_o=0100, 0x00821003 (ADDEQ) → reg_write=1; 0x10821003 (ADDNE) → reg_write=0.
- Assert reset during MEMREAD of an LDR → state_o=0 and flags_o=0 without waiting for a clock edge; all write enables 0 while reset=1; first ir_write=1 is in FETCH on the first edge after release.
